// File: rtl/decoder_pkg.sv
// Shared types and sizes for the decoder_2to4 scan controller.
package decoder_pkg;
    localparam int SEL_W     = 2;
    localparam int NUM_LINES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } state_t;
endpackage

// File: rtl/scan_next_sel.sv
// Picks the next enabled decoder line: the lowest set mask bit when first_i,
// otherwise the next set bit above cur_i. is_last_o flags cur_i as the highest set bit.
module scan_next_sel
    import decoder_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask_i,
    input  logic [SEL_W-1:0]     cur_i,
    input  logic                 first_i,
    output logic [SEL_W-1:0]     next_o,
    output logic                 is_last_o
);

    always_comb begin
        next_o    = cur_i;
        is_last_o = 1'b1;
        // Walk downwards so the lowest qualifying bit is the one that sticks.
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
                next_o = SEL_W'(i);
            end
            if (mask_i[i] && (i > int'(cur_i))) begin
                is_last_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans a programmable subset of decoder_2to4 outputs with a programmable dwell,
// keeping en low for a LOAD cycle around every {A,B} change.
module decoder_scan_ctrl
    import decoder_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               A,
    output logic               B,
    output logic               en,
    output logic               busy,
    output logic               line_done,
    output logic               frame_done
);

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [NUM_LINES-1:0]   mask_q, mask_d;
    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic                   cont_q, cont_d;
    logic [DWELL_W-1:0]     cnt_q, cnt_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   ld_q, ld_d;
    logic                   fd_q, fd_d;

    logic [SEL_W-1:0]       step_next;
    logic                   step_last;
    logic [SEL_W-1:0]       first_sel;
    logic                   unused_first_last;

    function automatic logic [DWELL_W-1:0] clamp_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    scan_next_sel u_step (
        .mask_i    (mask_q),
        .cur_i     (sel_q),
        .first_i   (1'b0),
        .next_o    (step_next),
        .is_last_o (step_last)
    );

    scan_next_sel u_first (
        .mask_i    (mask),
        .cur_i     (sel_q),
        .first_i   (1'b1),
        .next_o    (first_sel),
        .is_last_o (unused_first_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ld_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ld_q    <= ld_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop && (mask != '0)) begin
                        state_d = LOAD;
                        mask_d  = mask;
                        dwell_d = clamp_dwell(dwell);
                        cont_d  = cont;
                        sel_d   = first_sel;
                    end
                end
                LOAD: begin
                    state_d = DWELL;
                    cnt_d   = dwell_q;
                end
                DWELL: begin
                    if (cnt_q > DWELL_W'(1)) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (!step_last) begin
                            sel_d   = step_next;
                            state_d = LOAD;
                        end else if (cont_q && (mask != '0)) begin
                            // Frame boundary: pick up the new programming.
                            mask_d  = mask;
                            dwell_d = clamp_dwell(dwell);
                            sel_d   = first_sel;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next state so they register in the cycle they describe.
    always_comb begin
        en_d   = (state_d == DWELL);
        busy_d = (state_d != IDLE);
        ld_d   = (state_d == DWELL) && (cnt_d == DWELL_W'(1));
        fd_d   = ld_d && step_last;
    end

    assign A          = sel_q[1];
    assign B          = sel_q[0];
    assign en         = en_q;
    assign busy       = busy_q;
    assign line_done  = ld_q;
    assign frame_done = fd_q;

endmodule
